ode_param_loader: RTL and testbench

Write-side front end for the step-size controller's working memory. It accepts a word stream from the host over a valid/ready handshake and writes it into the shared parameter/state memory through a single write port. Stored items are N, tolerance, initial step, and the x0 and x1 vectors. It validates the vector regions before any vector write, then pulses `load_done`, which the top level routes to the step controller's `init`.

---
 rtl/ode_param_loader_pkg.sv | 24 ++
 rtl/ode_region_checker.sv | 44 ++++
 rtl/ode_param_loader.sv | 190 +++++++++++++++++++
 tb/tb_ode_param_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ode_param_loader_pkg.sv
// Shared constants and state encoding for the ODE parameter loader.
// The step controller imports the same header addresses so both ends agree
// on where N, tolerance and initial step live.
package ode_param_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_N,
    ST_GET_TOL,
    ST_GET_STEP,
    ST_GET_X0,
    ST_GET_X1,
    ST_FINISH,
    ST_ERROR
  } loader_state_t;

  localparam int N_ADDRESS         = 5;
  localparam int TOLERANCE_ADDRESS = 6;
  localparam int STEP_ADDRESS      = 7;
  // First address past the three header words; vector regions must sit
  // entirely below N_ADDRESS or start at or above this address.
  localparam int HEADER_END        = 8;

endpackage

// File: rtl/ode_region_checker.sv
// Combinational validation of the x0/x1 vector regions for a given length N.
// Sums are formed one bit wider than the data word so an oversized N can
// never wrap around and look legal.
module ode_region_checker
  import ode_param_loader_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic [WORD_SIZE-1:0]     n_i,
  input  logic [ADDRESS_WIDTH-1:0] x0_base_i,
  input  logic [ADDRESS_WIDTH-1:0] x1_base_i,
  output logic                     ok_o
);

  localparam int SW = WORD_SIZE + 1;
  localparam logic [SW-1:0] DEPTH  = SW'(2 ** ADDRESS_WIDTH);
  localparam logic [SW-1:0] HDR_LO = SW'(N_ADDRESS);
  localparam logic [SW-1:0] HDR_HI = SW'(HEADER_END);

  logic [SW-1:0] n_w;
  logic [SW-1:0] b0_w;
  logic [SW-1:0] b1_w;
  logic [SW-1:0] e0_w;
  logic [SW-1:0] e1_w;
  logic          fit_w;
  logic          hdr_w;
  logic          disj_w;

  // Widen operands, form region ends and evaluate every acceptance rule.
  always_comb begin
    n_w    = {1'b0, n_i};
    b0_w   = SW'(x0_base_i);
    b1_w   = SW'(x1_base_i);
    e0_w   = b0_w + n_w;
    e1_w   = b1_w + n_w;
    fit_w  = (e0_w <= DEPTH) && (e1_w <= DEPTH);
    hdr_w  = ((e0_w <= HDR_LO) || (b0_w >= HDR_HI)) &&
             ((e1_w <= HDR_LO) || (b1_w >= HDR_HI));
    disj_w = (e0_w <= b1_w) || (e1_w <= b0_w);
    ok_o   = (n_i != '0) && fit_w && hdr_w && disj_w;
  end

endmodule

// File: rtl/ode_param_loader.sv
// Host-to-memory loader for the step controller's working memory: accepts a
// word stream (N, tolerance, initial step, x0[N], x1[N]) and writes it through
// a single registered write port, validating the vector regions up front.
module ode_param_loader
  import ode_param_loader_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] x0_base,
  input  logic [ADDRESS_WIDTH-1:0] x1_base,
  input  logic                     in_valid,
  input  logic [WORD_SIZE-1:0]     in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_data,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_error
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int WS = WORD_SIZE;

  loader_state_t state_q, state_d;
  logic [WS-1:0] n_q, n_d;
  logic [WS-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] x0b_q, x0b_d;
  logic [AW-1:0] x1b_q, x1b_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [WS-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          region_ok_w;
  logic          xfer_w;

  // Checks use the word currently on the bus against the latched bases.
  ode_region_checker #(
    .WORD_SIZE     (WS),
    .ADDRESS_WIDTH (AW)
  ) u_region_checker (
    .n_i       (in_data),
    .x0_base_i (x0b_q),
    .x1_base_i (x1b_q),
    .ok_o      (region_ok_w)
  );

  assign in_ready    = !abort && (state_q inside {ST_GET_N, ST_GET_TOL, ST_GET_STEP,
                                                  ST_GET_X0, ST_GET_X1});
  assign xfer_w      = in_valid && in_ready;
  assign busy        = (state_q != ST_IDLE);
  assign mem_we      = we_q;
  assign mem_address = waddr_q;
  assign mem_data    = wdata_q;
  assign load_done   = done_q;
  assign load_error  = err_q;

  // Next-state, counters and the write request for the following cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    x0b_d   = x0b_q;
    x1b_d   = x1b_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start && !abort) begin
          x0b_d   = x0_base;
          x1b_d   = x1_base;
          err_d   = 1'b0;
          state_d = ST_GET_N;
        end
      end
      ST_GET_N: begin
        if (xfer_w) begin
          if (region_ok_w) begin
            n_d     = in_data;
            cnt_d   = in_data;
            we_d    = 1'b1;
            waddr_d = AW'(N_ADDRESS);
            wdata_d = in_data;
            state_d = ST_GET_TOL;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_GET_TOL: begin
        if (xfer_w) begin
          we_d    = 1'b1;
          waddr_d = AW'(TOLERANCE_ADDRESS);
          wdata_d = in_data;
          state_d = ST_GET_STEP;
        end
      end
      ST_GET_STEP: begin
        if (xfer_w) begin
          we_d    = 1'b1;
          waddr_d = AW'(STEP_ADDRESS);
          wdata_d = in_data;
          addr_d  = x0b_q;
          state_d = ST_GET_X0;
        end
      end
      ST_GET_X0: begin
        if (xfer_w) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          if (cnt_q == WS'(1)) begin
            cnt_d   = n_q;
            addr_d  = x1b_q;
            state_d = ST_GET_X1;
          end else begin
            cnt_d  = cnt_q - WS'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_GET_X1: begin
        if (xfer_w) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          if (cnt_q == WS'(1)) begin
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            cnt_d  = cnt_q - WS'(1);
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Abort wins over everything outside IDLE; in_ready is already low so no
    // word of this cycle can be written.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // State, counters, latched bases and the registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      x0b_q   <= '0;
      x1b_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      x0b_q   <= x0b_d;
      x1b_q   <= x1b_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ode_param_loader.sv
// Randomized bench for ode_param_loader: each load is predicted from the
// region rules and the memory map, then compared against observed writes.
module tb_ode_param_loader;

  localparam int WS    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          load_start;
  logic          abort;
  logic [AW-1:0] x0_base;
  logic [AW-1:0] x1_base;
  logic          in_valid;
  logic [WS-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [WS-1:0] mem_data;
  logic          busy;
  logic          load_done;
  logic          load_error;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc_g    = 0;

  int            obs_a[$];
  logic [WS-1:0] obs_d[$];
  int            obs_c[$];
  int            done_cnt;
  int            done_c;

  ode_param_loader #(
    .WORD_SIZE     (WS),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .abort       (abort),
    .x0_base     (x0_base),
    .x1_base     (x1_base),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .busy        (busy),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Record every write and load_done pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_a.push_back(int'(mem_address));
      obs_d.push_back(mem_data);
      obs_c.push_back(cyc_g);
    end
    if (load_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_c   = cyc_g;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Acceptance rule for a load, written directly from the region rules.
  function automatic bit model_ok(input int b0, input int b1, input int n);
    int e0, e1;
    e0 = b0 + n;
    e1 = b1 + n;
    return (n != 0) && (e0 <= DEPTH) && (e1 <= DEPTH) &&
           ((e0 <= 5) || (b0 >= 8)) && ((e1 <= 5) || (b1 >= 8)) &&
           ((e0 <= b1) || (e1 <= b0));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_we"},    32'(mem_we), 32'd0);
    check_eq({tag, "_addr"},  32'(mem_address), 32'd0);
    check_eq({tag, "_data"},  32'(mem_data), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_done"},  32'(load_done), 32'd0);
    check_eq({tag, "_err"},   32'(load_error), 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
  endtask

  // gap: 0 back-to-back, 1 valid every other cycle, 2 random gaps plus
  // stray load_start pulses. abort_at / rst_at: transfer index, -1 = unused.
  task automatic do_load(input int b0, input int b1, input int n, input int gap,
                         input int abort_at, input int rst_at);
    logic [WS-1:0] words[$];
    int            exp_a[$];
    logic [WS-1:0] exp_d[$];
    bit            ok;
    bit            v;
    int            total, stop, nexp, idx, cyc;

    ok = model_ok(b0, b1, n);
    words.push_back(WS'(n));
    for (int i = 0; i < 2 + 2 * n; i++) words.push_back(WS'($urandom));
    if (ok) begin
      exp_a.push_back(5); exp_d.push_back(words[0]);
      exp_a.push_back(6); exp_d.push_back(words[1]);
      exp_a.push_back(7); exp_d.push_back(words[2]);
      for (int i = 0; i < n; i++) begin
        exp_a.push_back(b0 + i); exp_d.push_back(words[3 + i]);
      end
      for (int i = 0; i < n; i++) begin
        exp_a.push_back(b1 + i); exp_d.push_back(words[3 + n + i]);
      end
    end
    total = ok ? 3 + 2 * n : 1;
    stop  = (abort_at >= 0) ? abort_at : total;
    nexp  = ok ? stop : 0;

    obs_a.delete(); obs_d.delete(); obs_c.delete();
    done_cnt = 0;
    done_c   = -1;

    @(negedge clk);
    x0_base    = AW'(b0);
    x1_base    = AW'(b1);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_err_clr", 32'(load_error), 32'd0);

    idx = 0;
    cyc = 0;
    while (idx < stop && cyc < 400) begin
      if (rst_at >= 0 && idx == rst_at) begin
        in_valid   = 1'b0;
        load_start = 1'b0;
        #2 rst = 1'b0;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (gap == 2) begin
        load_start = ($urandom_range(0, 3) == 0);
        x0_base    = AW'($urandom);
        x1_base    = AW'($urandom);
      end
      in_valid = v;
      in_data  = v ? words[idx] : WS'($urandom);
      #1;
      if (v && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    check_eq("xfer_count", 32'(idx), 32'(stop));

    if (abort_at >= 0) begin
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = words[idx];
      #1 check_eq("abort_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      check_eq("post_abort_ready", 32'(in_ready), 32'd0);
      check_eq("post_abort_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
    end else if (!ok) begin
      check_eq("err_rise", 32'(load_error), 32'd1);
      check_eq("err_busy1", 32'(busy), 32'd1);
      @(negedge clk);
      check_eq("err_busy_drop", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end

    check_eq("n_writes", 32'(obs_a.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < obs_a.size(); i++) begin
      check_eq($sformatf("waddr[%0d]", i), 32'(obs_a[i]), 32'(exp_a[i]));
      check_eq($sformatf("wdata[%0d]", i), 32'(obs_d[i]), 32'(exp_d[i]));
    end
    check_eq("done_count", 32'(done_cnt), (ok && abort_at < 0) ? 32'd1 : 32'd0);
    if (ok && abort_at < 0 && obs_c.size() > 0) begin
      check_eq("done_with_last_we", 32'(done_c), 32'(obs_c[obs_c.size() - 1]));
      if (gap == 0)
        check_eq("b2b_span", 32'(obs_c[obs_c.size() - 1] - obs_c[0]), 32'(total - 1));
      if (gap == 1)
        check_eq("bp_span", 32'(obs_c[obs_c.size() - 1] - obs_c[0]), 32'(2 * (total - 1)));
    end
    check_eq("final_err", 32'(load_error), ok ? 32'd0 : 32'd1);
    check_eq("final_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    load_start = 1'b0;
    abort      = 1'b0;
    x0_base    = '0;
    x1_base    = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    done_cnt   = 0;
    done_c     = -1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    do_load(8, 12, 4, 0, -1, -1);   // nominal
    do_load(0, 12, 5, 0, -1, -1);   // x1 region overflows memory
    do_load(4, 12, 2, 0, -1, -1);   // x0 overlaps header
    do_load(8, 12, 0, 0, -1, -1);   // zero length
    do_load(8, 12, 4, 1, -1, -1);   // backpressure
    do_load(8, 12, 4, 0, 5, -1);    // abort after second x0 word
    do_load(8, 12, 4, 0, -1, -1);   // new load after abort

    // load_start together with abort in IDLE must be ignored
    @(negedge clk);
    load_start = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    abort      = 1'b0;
    check_eq("start_abort_idle", 32'(busy), 32'd0);

    do_load(8, 12, 4, 0, -1, 8);    // reset during x1
    do_load(8, 12, 4, 0, -1, -1);   // nominal after reset

    for (int k = 0; k < 25; k++) begin
      do_load($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 6), $urandom_range(0, 2), -1, -1);
    end
    do_load(0, 8, 5, 2, -1, -1);
    do_load(10, 0, 5, 2, -1, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
